// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message-schedule sequencer.
package sha256_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned WORDS_PER_BLOCK = 16;
  localparam int unsigned ROUNDS          = 64;
  localparam int unsigned IDX_W           = 6;
  localparam int unsigned LOAD_W          = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/sha256_small_sigma.sv
// Combinational SHA-256 small-sigma function; SEL=0 gives sigma0, SEL=1 gives sigma1.
module sha256_small_sigma
  import sha256_pkg::*;
#(
  parameter int unsigned SEL = 0
) (
  input  word_t x,
  output word_t y
);

  word_t rot_a;
  word_t rot_b;
  word_t shr_c;

  always_comb begin
    rot_a = '0;
    rot_b = '0;
    shr_c = '0;
    if (SEL == 0) begin
      rot_a = {x[6:0],  x[31:7]};
      rot_b = {x[17:0], x[31:18]};
      shr_c = {3'b000,  x[31:3]};
    end else begin
      rot_a = {x[16:0], x[31:17]};
      rot_b = {x[18:0], x[31:19]};
      shr_c = {10'b0,   x[31:10]};
    end
    y = rot_a ^ rot_b ^ shr_c;
  end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule sequencer: loads 16 words, streams W0..W63 from a sliding window.
// Optional statistics counters are built when SHA256_SCHED_STATS_EN is defined.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [5:0]       out_idx,
  output logic             busy,
  output logic             done
`ifdef SHA256_SCHED_STATS_EN
  ,
  output logic [31:0]      blk_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  localparam logic [LOAD_W-1:0] LAST_LOAD  = LOAD_W'(WORDS_PER_BLOCK - 1);
  localparam logic [IDX_W-1:0]  LAST_ROUND = IDX_W'(ROUNDS - 1);

  state_t             state;
  state_t             state_next;
  word_t              win [WORDS_PER_BLOCK];
  logic [LOAD_W-1:0]  load_cnt;
  logic [IDX_W-1:0]   t;
  logic               in_fire;
  logic               out_fire;
  word_t              s0_y;
  word_t              s1_y;
  word_t              sched_next;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign out_data  = win[0];
  assign out_idx   = t;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  sha256_small_sigma #(.SEL(0)) u_sigma0 (
    .x (win[1]),
    .y (s0_y)
  );

  sha256_small_sigma #(.SEL(1)) u_sigma1 (
    .x (win[14]),
    .y (s1_y)
  );

  assign sched_next = s1_y + win[9] + s0_y + win[0];

  // The done cycle is already IDLE, so a start coinciding with done is masked here.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !done) state_next = LOAD;
      LOAD:    if (in_fire && (load_cnt == LAST_LOAD)) state_next = EMIT;
      EMIT:    if (out_fire && (t == LAST_ROUND)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt <= '0;
      t        <= '0;
      done     <= 1'b0;
    end else begin
      done <= out_fire && (t == LAST_ROUND);
      if ((state == IDLE) && start && !done) begin
        load_cnt <= '0;
        t        <= '0;
      end
      if (in_fire) begin
        load_cnt <= load_cnt + 1'b1;
      end
      if (out_fire) begin
        t <= t + 1'b1;
      end
    end
  end

  // Loading and emitting share one shift path; only the word entering slot 15 differs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WORDS_PER_BLOCK; i++) begin
        win[i] <= '0;
      end
    end else if (in_fire || out_fire) begin
      for (int unsigned i = 0; i < WORDS_PER_BLOCK - 1; i++) begin
        win[i] <= win[i+1];
      end
      win[WORDS_PER_BLOCK-1] <= in_fire ? in_data : sched_next;
    end
  end

`ifdef SHA256_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (done) begin
        blk_cnt <= blk_cnt + 32'd1;
      end
      if (out_valid && !out_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed self-checking bench for sha256_msg_sched; covers stats ports when SHA256_SCHED_STATS_EN is defined.
module tb_sha256_msg_sched;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        busy;
  logic        done;
`ifdef SHA256_SCHED_STATS_EN
  logic [31:0] blk_cnt;
  logic [31:0] stall_cnt;
`endif

  int          n_checks;
  int          n_pass;
  int          stall_seen;
  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  sha256_msg_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
`ifdef SHA256_SCHED_STATS_EN
    ,
    .blk_cnt   (blk_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic build_expected();
    for (int i = 0; i < 16; i++) exp_w[i] = msg[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = ref_s1(exp_w[i-2]) + exp_w[i-7] + ref_s0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic set_msg(input int kind);
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    if (kind == 0) begin
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
    end else if (kind == 1) begin
      msg[1]  = 32'h00000001;
    end
    build_expected();
  endtask

  task automatic load_block(input bit poke);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("in_ready_after_start", 32'(in_ready), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = msg[i];
      start    = poke && (i == 5);
      check("in_ready_load", 32'(in_ready), 32'd1);
      check("out_valid_load", 32'(out_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("out_valid_after_load", 32'(out_valid), 32'd1);
  endtask

  task automatic emit_block(input bit rand_stall, input bit poke, input int stop_at);
    int idx;
    int cyc;
    bit fire;
    idx = 0;
    cyc = 0;
    while (idx < stop_at && cyc < 1000) begin
      out_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) begin
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        start    = (cyc % 2) == 0;
      end
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_data", out_data, exp_w[idx]);
      check("out_idx", 32'(out_idx), 32'(idx));
      check("busy_emit", 32'(busy), 32'd1);
      check("done_early", 32'(done), 32'd0);
      if (poke) check("in_ready_emit", 32'(in_ready), 32'd0);
      if (!out_ready) stall_seen++;
      got_w[idx] = out_data;
      fire = out_valid && out_ready;
      tick();
      if (fire) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    if (cyc >= 1000) check("emit_timeout", 32'd0, 32'd1);
    if (stop_at == 64) begin
      check("done_pulse", 32'(done), 32'd1);
      check("busy_done", 32'(busy), 32'd0);
      check("out_valid_done", 32'(out_valid), 32'd0);
      start = poke;
      tick();
      start = 1'b0;
      check("done_single", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("in_ready_idle", 32'(in_ready), 32'd0);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    stall_seen = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 32'h0;
    out_ready  = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
`ifdef SHA256_SCHED_STATS_EN
    check("rst_blk_cnt", blk_cnt, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    // in_valid while idle must not start or feed anything
    in_valid = 1'b1;
    in_data  = 32'hCAFEF00D;
    repeat (3) tick();
    check("idle_ignore_in_ready", 32'(in_ready), 32'd0);
    check("idle_ignore_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    set_msg(0);
    load_block(1'b0);
    emit_block(1'b0, 1'b0, 64);
    check("abc_w16", got_w[16], 32'h61626380);
    check("abc_w17", got_w[17], 32'h000F0000);
    check("abc_w63", got_w[63], 32'h12B1EDEB);

    set_msg(1);
    load_block(1'b0);
    emit_block(1'b0, 1'b0, 64);
    check("sigma0_w16", got_w[16], 32'h02004000);

    set_msg(2);
    load_block(1'b0);
    emit_block(1'b0, 1'b0, 64);
    check("zero_w63", got_w[63], 32'h0);

    set_msg(0);
    load_block(1'b0);
    emit_block(1'b1, 1'b0, 64);
    check("stall_w63", got_w[63], 32'h12B1EDEB);
`ifdef SHA256_SCHED_STATS_EN
    check("stall_cnt", stall_cnt, 32'(stall_seen));
    check("blk_cnt_4", blk_cnt, 32'd4);
`endif

    set_msg(0);
    load_block(1'b0);
    emit_block(1'b0, 1'b0, 30);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_idx", 32'(out_idx), 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    load_block(1'b0);
    emit_block(1'b0, 1'b0, 64);
    check("post_rst_w0", got_w[0], 32'h61626380);
`ifdef SHA256_SCHED_STATS_EN
    check("blk_cnt_after_rst", blk_cnt, 32'd1);
`endif

    set_msg(0);
    load_block(1'b1);
    emit_block(1'b0, 1'b1, 64);
    check("poke_w17", got_w[17], 32'h000F0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
